// File: rtl/pmem_types.sv
// Shared types for the pmem responder: line type, FSM state encoding and
// the byte-offset width of a 32-byte line.
package pmem_types;

    typedef logic [255:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } pmem_state_t;

    localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/line_store.sv
// Single-port line array with write enable and a registered, enable-held read port.
module line_store
    import pmem_types::*;
#(
    parameter int INDEX_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [INDEX_BITS-1:0] addr,
    input  line_t                 wdata,
    output line_t                 rdata
);

    localparam int DEPTH = 1 << INDEX_BITS;

    line_t mem [DEPTH];

    // NOTE: the array itself is never reset; clearing 2^INDEX_BITS lines would
    // prevent RAM inference, so contents start undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The read register holds its value whenever no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Line-granular memory responder: latches a request, waits LATENCY cycles,
// then completes it with a one-cycle pmem_resp pulse; keeps stats and an error flag.
module pmem_responder
    import pmem_types::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int LATENCY    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  line_t       pmem_wdata,
    output line_t       pmem_rdata,
    output logic        pmem_resp,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        proto_err
);

    localparam int         IDX_LSB  = OFFSET_BITS;
    localparam int         IDX_MSB  = INDEX_BITS + OFFSET_BITS - 1;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    pmem_state_t           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  lat_write_q;
    logic [INDEX_BITS-1:0] lat_index_q;
    line_t                 lat_wdata_q;

    logic                  req;
    logic                  capture;
    logic                  err_set;
    logic                  resp_d;
    logic                  inc_rd;
    logic                  inc_wr;
    logic                  store_we;
    logic                  store_re;
    logic [INDEX_BITS-1:0] live_index;
    logic [INDEX_BITS-1:0] store_addr;
    line_t                 store_wdata;
    logic                  unused_addr_bits;

    assign req        = pmem_read | pmem_write;
    assign live_index = pmem_address[IDX_MSB:IDX_LSB];

    // Offset bits are ignored and the upper bits simply alias onto the index.
    assign unused_addr_bits = ^{pmem_address[31:IDX_MSB+1], pmem_address[IDX_LSB-1:0]};

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        err_set     = 1'b0;
        resp_d      = 1'b0;
        inc_rd      = 1'b0;
        inc_wr      = 1'b0;
        store_we    = 1'b0;
        store_re    = 1'b0;
        store_addr  = lat_index_q;
        store_wdata = lat_wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    err_set = pmem_read & pmem_write;
                    // With a one-cycle latency there is no WAIT phase, so the
                    // access is made straight from the live request.
                    if (LATENCY == 1) begin
                        store_addr  = live_index;
                        store_wdata = pmem_wdata;
                        store_we    = pmem_write;
                        store_re    = ~pmem_write;
                        inc_wr      = pmem_write;
                        inc_rd      = ~pmem_write;
                        resp_d      = 1'b1;
                        state_d     = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!req) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_set = (pmem_write != lat_write_q) || (live_index != lat_index_q);
                    // The access edge is the last WAIT edge, so RESP lands LATENCY
                    // cycles after the request cycle.
                    if (cnt_q == 8'd1) begin
                        store_we = lat_write_q;
                        store_re = ~lat_write_q;
                        inc_wr   = lat_write_q;
                        inc_rd   = ~lat_write_q;
                        resp_d   = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_index_q <= '0;
            lat_wdata_q <= '0;
            pmem_resp   <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
            proto_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pmem_resp <= resp_d;
            if (capture) begin
                lat_write_q <= pmem_write;
                lat_index_q <= live_index;
                lat_wdata_q <= pmem_wdata;
            end
            if (inc_rd) begin
                rd_count <= rd_count + 32'd1;
            end
            if (inc_wr) begin
                wr_count <= wr_count + 32'd1;
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

    line_store #(
        .INDEX_BITS (INDEX_BITS)
    ) u_line_store (
        .clk   (clk),
        .rst   (rst),
        .we    (store_we),
        .re    (store_re),
        .addr  (store_addr),
        .wdata (store_wdata),
        .rdata (pmem_rdata)
    );

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: two instances (LATENCY 8 and 1) checked every cycle
// against a transaction-level model, plus hand-computed literal checks.
module tb_pmem_responder;
    import pmem_types::*;

    localparam int IB = 10;

    typedef struct {
        int    due;
        bit    wr;
        int    idx;
        line_t data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pmem_read    [2];
    logic        pmem_write   [2];
    logic [31:0] pmem_address [2];
    line_t       pmem_wdata   [2];
    line_t       pmem_rdata   [2];
    logic        pmem_resp    [2];
    logic [31:0] rd_count     [2];
    logic [31:0] wr_count     [2];
    logic        proto_err    [2];

    always #5 clk = ~clk;

    pmem_responder #(.INDEX_BITS(IB), .LATENCY(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]),
        .pmem_address(pmem_address[0]), .pmem_wdata(pmem_wdata[0]),
        .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0]),
        .rd_count(rd_count[0]), .wr_count(wr_count[0]), .proto_err(proto_err[0])
    );

    pmem_responder #(.INDEX_BITS(IB), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]),
        .pmem_address(pmem_address[1]), .pmem_wdata(pmem_wdata[1]),
        .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1]),
        .rd_count(rd_count[1]), .wr_count(wr_count[1]), .proto_err(proto_err[1])
    );

    // ---------------- model state ----------------
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    txn_t        q0[$];
    txn_t        q1[$];
    line_t       mem0[int];
    line_t       mem1[int];
    line_t       m_rdata [2];
    logic [31:0] m_rd    [2];
    logic [31:0] m_wr    [2];
    logic        m_err   [2];
    int          err_at  [2];
    int          last_resp [2];
    int          resp_log1[$];
    bit          cmp_resp;
    txn_t        cmp_t;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 8 : 1;
    endfunction

    function automatic line_t mem_get(input int d, input int idx);
        if (d == 0 && mem0.exists(idx)) return mem0[idx];
        if (d == 1 && mem1.exists(idx)) return mem1[idx];
        return 'x;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_rdata[d] = '0;
            m_rd[d]    = '0;
            m_wr[d]    = '0;
            m_err[d]   = 1'b0;
            err_at[d]  = 32'h7fff_ffff;
        end
    endtask

    task automatic flag_err(input int d, input int when);
        if (when < err_at[d]) err_at[d] = when;
    endtask

    task automatic apply_txn(input int d, input txn_t t);
        if (t.wr) begin
            if (d == 0) mem0[t.idx] = t.data;
            else        mem1[t.idx] = t.data;
            m_wr[d] = m_wr[d] + 32'd1;
        end else begin
            m_rdata[d] = mem_get(d, t.idx);
            m_rd[d]    = m_rd[d] + 32'd1;
        end
    endtask

    // Compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            cmp_resp = 1'b0;
            if (d == 0 && q0.size() != 0 && q0[0].due == cyc) begin
                cmp_t = q0.pop_front();
                cmp_resp = 1'b1;
            end
            if (d == 1 && q1.size() != 0 && q1[0].due == cyc) begin
                cmp_t = q1.pop_front();
                cmp_resp = 1'b1;
            end
            if (cmp_resp) apply_txn(d, cmp_t);
            if (cyc >= err_at[d]) m_err[d] = 1'b1;
            check($sformatf("d%0d cyc%0d pmem_resp", d, cyc), pmem_resp[d], cmp_resp);
            check($sformatf("d%0d cyc%0d pmem_rdata", d, cyc), pmem_rdata[d], m_rdata[d]);
            check($sformatf("d%0d cyc%0d rd_count", d, cyc), rd_count[d], m_rd[d]);
            check($sformatf("d%0d cyc%0d wr_count", d, cyc), wr_count[d], m_wr[d]);
            check($sformatf("d%0d cyc%0d proto_err", d, cyc), proto_err[d], m_err[d]);
            if (pmem_resp[d] === 1'b1) last_resp[d] = cyc;
        end
        if (pmem_resp[1] === 1'b1) resp_log1.push_back(cyc);
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        pmem_read[d]    = 1'b0;
        pmem_write[d]   = 1'b0;
        pmem_address[d] = '0;
        pmem_wdata[d]   = '0;
    endtask

    // Raise a request in the current cycle and post its expected completion.
    task automatic start(input int d, input bit wr, input bit rd, input logic [31:0] addr, input line_t data);
        txn_t t;
        pmem_read[d]    = rd;
        pmem_write[d]   = wr;
        pmem_address[d] = addr;
        pmem_wdata[d]   = data;
        t.due  = cyc + lat(d);
        t.wr   = wr;
        t.idx  = int'(addr[IB+4:5]);
        t.data = data;
        if (d == 0) q0.push_back(t);
        else        q1.push_back(t);
        if (wr && rd) flag_err(d, cyc + 1);
    endtask

    // Full transaction: request held through the response, dropped on the edge ending it.
    task automatic xact(input int d, input bit wr, input bit rd, input logic [31:0] addr, input line_t data);
        start(d, wr, rd, addr, data);
        step(lat(d) + 1);
        idle(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        line_t a5, lx, ly, lz, lb, lw;
        int    t0;
        int    exp_off [4];
        a5 = {32{8'hA5}};
        lx = {8{32'hDEAD_BEEF}};
        ly = {16{16'h1234}};
        lz = {4{64'h0123_4567_89AB_CDEF}};
        lb = {32{8'h3C}};
        lw = {8{32'hCAFE_F00D}};
        exp_off = '{1, 3, 5, 7};
        last_resp[0] = -1;
        last_resp[1] = -1;
        idle(0);
        idle(1);
        model_reset();

        // Asynchronous reset between edges: outputs must be zero at once.
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset resp", d), pmem_resp[d], 1'b0);
            check($sformatf("d%0d reset rdata", d), pmem_rdata[d], '0);
            check($sformatf("d%0d reset rd_count", d), rd_count[d], 32'd0);
            check($sformatf("d%0d reset wr_count", d), wr_count[d], 32'd0);
            check($sformatf("d%0d reset proto_err", d), proto_err[d], 1'b0);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step(20);

        // Write then read, LATENCY=8.
        t0 = cyc;
        xact(0, 1'b1, 1'b0, 32'h0000_0040, a5);
        check("write latency", 256'(last_resp[0] - t0), 256'd8);
        t0 = cyc;
        xact(0, 1'b0, 1'b1, 32'h0000_0040, '0);
        check("read latency", 256'(last_resp[0] - t0), 256'd8);
        check("read data A5", pmem_rdata[0], a5);
        check("rd_count after 1 read", rd_count[0], 32'd1);
        check("wr_count after 1 write", wr_count[0], 32'd1);

        // Offset ignore and upper-bit aliasing.
        xact(0, 1'b1, 1'b0, 32'h0000_0020, lx);
        xact(0, 1'b0, 1'b1, 32'h0000_003F, '0);
        check("offset ignored", pmem_rdata[0], lx);
        xact(0, 1'b0, 1'b1, 32'h0000_8020, '0);
        check("upper bits alias", pmem_rdata[0], lx);

        // Back-to-back reads, LATENCY=1, request held through four responses.
        xact(1, 1'b1, 1'b0, 32'h0000_0100, ly);
        resp_log1.delete();
        t0 = cyc;
        pmem_read[1]    = 1'b1;
        pmem_address[1] = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            txn_t t;
            t.due  = t0 + exp_off[k];
            t.wr   = 1'b0;
            t.idx  = 8;
            t.data = '0;
            q1.push_back(t);
        end
        step(8);
        idle(1);
        check("b2b response count", 256'(resp_log1.size()), 256'd4);
        for (int k = 0; k < 4; k++) begin
            int got;
            got = (k < resp_log1.size()) ? resp_log1[k] - t0 : -1;
            check($sformatf("b2b response %0d cycle", k), 256'(got), 256'(exp_off[k]));
        end
        check("b2b rd_count", rd_count[1], 32'd4);
        check("b2b read data", pmem_rdata[1], ly);

        // Simultaneous read and write is a write plus an error.
        xact(1, 1'b1, 1'b1, 32'h0000_0100, lz);
        check("simultaneous rw sets proto_err", proto_err[1], 1'b1);
        xact(1, 1'b0, 1'b1, 32'h0000_0100, '0);
        check("simultaneous rw wrote", pmem_rdata[1], lz);

        // Abort: write dropped in WAIT cycle 3.
        start(0, 1'b1, 1'b0, 32'h0000_0040, {32{8'h5A}});
        step(3);
        idle(0);
        q0.delete();
        flag_err(0, cyc + 1);
        step(10);
        check("abort wr_count unchanged", wr_count[0], 32'd2);
        check("abort proto_err", proto_err[0], 1'b1);
        xact(0, 1'b0, 1'b1, 32'h0000_0040, '0);
        check("abort keeps old line", pmem_rdata[0], a5);

        // Reset during WAIT of a write: nothing committed.
        start(0, 1'b1, 1'b0, 32'h0000_0040, lb);
        step(4);
        #2 rst = 1'b1;
        idle(0);
        model_reset();
        #1;
        check("mid reset resp", pmem_resp[0], 1'b0);
        check("mid reset rdata", pmem_rdata[0], '0);
        check("mid reset rd_count", rd_count[0], 32'd0);
        check("mid reset wr_count", wr_count[0], 32'd0);
        check("mid reset proto_err", proto_err[0], 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        step(1);
        xact(0, 1'b0, 1'b1, 32'h0000_0040, '0);
        check("reset dropped pending write", pmem_rdata[0], a5);
        check("rd_count after reset", rd_count[0], 32'd1);

        // Address change during WAIT: error, latched address still used.
        start(0, 1'b1, 1'b0, 32'h0000_0060, lw);
        step(2);
        pmem_address[0] = 32'h0000_0080;
        flag_err(0, cyc + 1);
        step(7);
        idle(0);
        check("addr change proto_err", proto_err[0], 1'b1);
        check("addr change wr_count", wr_count[0], 32'd1);
        xact(0, 1'b0, 1'b1, 32'h0000_0060, '0);
        check("latched address used", pmem_rdata[0], lw);

        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
